apb_arbiter: RTL

- Shares one APB4 completer port between NREQ local requesters, each with a simple req/done command interface.
- Round-robin arbitration selects a requester.
- A SETUP/ACCESS state machine drives the APB bus and returns read data and error status to the granted requester.
- Sits between on-chip masters and the APB slave, in place of a single dedicated APB driver.

---
 rtl/apb_arbiter_if.sv | 27 ++
 rtl/apb_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter_if.sv
// APB4 completer-side bus bundle shared by the arbiter (master) and the slave.
interface apb_arbiter_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32,
    parameter int SWIDTH = 4
);
    logic              o_sel;
    logic              o_enable;
    logic              o_write;
    logic [AWIDTH-1:0] o_addr;
    logic [DWIDTH-1:0] o_wdata;
    logic [SWIDTH-1:0] o_strb;
    logic [2:0]        o_prot;
    logic [DWIDTH-1:0] i_rdata;
    logic              i_ready;
    logic              i_slverr;

    modport master (
        output o_sel, o_enable, o_write, o_addr, o_wdata, o_strb, o_prot,
        input  i_rdata, i_ready, i_slverr
    );

    modport slave (
        input  o_sel, o_enable, o_write, o_addr, o_wdata, o_strb, o_prot,
        output i_rdata, i_ready, i_slverr
    );
endinterface

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB4 port between NREQ req/done requesters.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | bus idle; pick next eligible requester, capture its command
// ST_SETUP  | PSEL=1, PENABLE=0 for one cycle
// ST_ACCESS | PSEL=1, PENABLE=1 until PREADY or the wait timer expires
module apb_arbiter #(
    parameter int NREQ    = 2,
    parameter int AWIDTH  = 12,
    parameter int DWIDTH  = 32,
    parameter int SWIDTH  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     i_clk,
    input  logic                     i_arst,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*AWIDTH-1:0]   i_reqAddr,
    input  logic [NREQ-1:0]          i_reqWrite,
    input  logic [NREQ*DWIDTH-1:0]   i_reqWData,
    input  logic [NREQ*SWIDTH-1:0]   i_reqStrb,
    input  logic [NREQ*3-1:0]        i_reqProt,
    output logic [NREQ-1:0]          o_done,
    output logic [DWIDTH-1:0]        o_rdata,
    output logic                     o_slverr,
    output logic [NREQ-1:0]          o_grant,
    apb_arbiter_if.master            apb
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ-1);
    localparam logic [CW-1:0] TMO_LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT-1) : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              sel_q, sel_d;
    logic              en_q, en_d;
    logic              write_q, write_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [SWIDTH-1:0] strb_q, strb_d;
    logic [2:0]        prot_q, prot_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              slverr_q, slverr_d;

    logic [NREQ-1:0]   eligible;
    logic [PW:0]       cand;
    logic [PW-1:0]     pick_idx;
    logic              timeout_hit;
    logic              complete;

    // Round-robin pick: first eligible index at or after the pointer, wrapping.
    // The done mask keeps a requester from being re-issued while its pulse is visible.
    always_comb begin
        eligible = i_req & ~done_q;
        pick_idx = ptr_q;
        cand     = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (eligible[cand[PW-1:0]]) pick_idx = cand[PW-1:0];
        end
    end

    // The wait timer counts down from TIMEOUT-1; expiry is a zero count with no ready.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == '0) && !apb.i_ready;
    assign complete    = (state_q == ST_ACCESS) && (apb.i_ready || timeout_hit);

    // State register and all registered outputs.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            sel_q    <= 1'b0;
            en_q     <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prot_q   <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            prot_q   <= prot_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
        end
    end

    // Next-state and wait timer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = TMO_LOAD;
            end
            ST_ACCESS: begin
                if (complete) state_d = ST_IDLE;
                else if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the bus, grant, done and result registers.
    always_comb begin
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        done_d   = '0;
        sel_d    = sel_q;
        en_d     = en_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        prot_d   = prot_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    gidx_d            = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    sel_d             = 1'b1;
                    en_d              = 1'b0;
                    write_d           = i_reqWrite[pick_idx];
                    addr_d            = i_reqAddr[pick_idx*AWIDTH +: AWIDTH];
                    prot_d            = i_reqProt[pick_idx*3 +: 3];
                    wdata_d           = i_reqWrite[pick_idx] ? i_reqWData[pick_idx*DWIDTH +: DWIDTH] : '0;
                    strb_d            = i_reqWrite[pick_idx] ? i_reqStrb[pick_idx*SWIDTH +: SWIDTH] : '0;
                end
            end
            ST_SETUP: begin
                en_d = 1'b1;
            end
            ST_ACCESS: begin
                if (complete) begin
                    done_d[gidx_q] = 1'b1;
                    sel_d          = 1'b0;
                    en_d           = 1'b0;
                    grant_d        = '0;
                    ptr_d          = (gidx_q == LAST_IDX) ? '0 : gidx_q + PW'(1);
                    slverr_d       = apb.i_ready ? apb.i_slverr : 1'b1;
                    rdata_d        = (apb.i_ready && !write_q) ? apb.i_rdata : '0;
                end
            end
            default: ;
        endcase
    end

    assign o_done       = done_q;
    assign o_rdata      = rdata_q;
    assign o_slverr     = slverr_q;
    assign o_grant      = grant_q;
    assign apb.o_sel    = sel_q;
    assign apb.o_enable = en_q;
    assign apb.o_write  = write_q;
    assign apb.o_addr   = addr_q;
    assign apb.o_wdata  = wdata_q;
    assign apb.o_strb   = strb_q;
    assign apb.o_prot   = prot_q;
endmodule
